// File: rtl/pong_pkg.sv
// Shared constants, types and render FSM states for the pong frame renderer.
package pong_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int BALL_SIZE = 5;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 120;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t FG_RGB = 12'hFFF;
  localparam rgb12_t BG_RGB = 12'h000;

  localparam logic [9:0] BALL_X_RST = 10'd318;
  localparam logic [9:0] BALL_Y_RST = 10'd238;
  localparam logic [9:0] P1_X_RST   = 10'd20;
  localparam logic [9:0] P1_Y_RST   = 10'd180;
  localparam logic [9:0] P2_X_RST   = 10'd610;
  localparam logic [9:0] P2_Y_RST   = 10'd180;

  typedef enum logic [1:0] {IDLE, LATCH, DRAW} render_state_t;

  // One-axis hit test; 11-bit sum so pos+size never wraps past 1023.
  function automatic logic span_hit(input logic [9:0] coord, input logic [9:0] pos,
                                    input logic [10:0] size);
    return ({1'b0, coord} >= {1'b0, pos}) && ({1'b0, coord} < ({1'b0, pos} + size));
  endfunction

endpackage

// File: rtl/score_digit_glyph.sv
// Combinational 7-segment glyph (20x40 px, 4 px strokes); hit_o is high when
// the pixel lies on a lit segment of digit_i. Values 10-15 light nothing.
module score_digit_glyph (
  input  logic [3:0] digit_i,
  input  logic [9:0] org_x_i,
  input  logic [9:0] org_y_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       hit_o
);

  logic [6:0]  seg;  // {g,f,e,d,c,b,a}
  logic [10:0] dx, dy;
  logic        in_box, top, bot, mid, left, right, upper;

  always_comb begin
    unique case (digit_i)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

  assign dx     = {1'b0, x_i} - {1'b0, org_x_i};
  assign dy     = {1'b0, y_i} - {1'b0, org_y_i};
  assign in_box = (x_i >= org_x_i) && (y_i >= org_y_i) && (dx < 11'd20) && (dy < 11'd40);
  assign top    = dy < 11'd4;
  assign bot    = dy >= 11'd36;
  assign mid    = (dy >= 11'd18) && (dy < 11'd22);
  assign left   = dx < 11'd4;
  assign right  = dx >= 11'd16;
  assign upper  = dy < 11'd20;

  assign hit_o = in_box && ((seg[0] && top) || (seg[1] && right && upper) ||
                            (seg[2] && right && !upper) || (seg[3] && bot) ||
                            (seg[4] && left && !upper) || (seg[5] && left && upper) ||
                            (seg[6] && mid));

endmodule

// File: rtl/pong_frame_renderer.sv
// Snapshots ball/paddle positions at vertical blank and renders them through a
// 2-stage compare pipeline. Define SCORE_DISPLAY_EN to draw the two score digits.
module pong_frame_renderer
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  X_pix,
  input  logic [9:0]  Y_pix,
  input  logic        video_on,
  input  logic [9:0]  ball_x_location,
  input  logic [9:0]  ball_y_location,
  input  logic [9:0]  P1_paddle_x_location,
  input  logic [9:0]  P1_paddle_y_location,
  input  logic [9:0]  P2_paddle_x_location,
  input  logic [9:0]  P2_paddle_y_location,
  input  logic [3:0]  P1_score,
  input  logic [3:0]  P2_score,
  output logic [11:0] rgb,
  output logic        video_on_d,
  output logic        frame_tick
);

  render_state_t state_q, state_d;
  logic blank_cond, blank_q, blank_entry, latch_en;

  logic [9:0] ball_x_q, ball_y_q, p1_x_q, p1_y_q, p2_x_q, p2_y_q;
  logic       ball_hit_q, p1_hit_q, p2_hit_q, net_hit_q, digit_hit_q, video_on_1_q;
  logic       ball_hit_d, p1_hit_d, p2_hit_d, net_hit_d, digit_hit_d;
  rgb12_t     rgb_q, rgb_d;
  logic       video_on_2_q;

  // Edge-detected so holding the blank coordinate cannot re-trigger a latch.
  assign blank_cond  = (X_pix == 10'd0) && (Y_pix == 10'(V_ACTIVE));
  assign blank_entry = blank_cond && !blank_q;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE:    if (blank_entry) state_d = LATCH;
      LATCH: begin
        latch_en = 1'b1;
        state_d  = DRAW;
      end
      DRAW:    if (blank_entry) state_d = LATCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_cond;
    end
  end

  assign frame_tick = latch_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x_q <= BALL_X_RST;
      ball_y_q <= BALL_Y_RST;
      p1_x_q   <= P1_X_RST;
      p1_y_q   <= P1_Y_RST;
      p2_x_q   <= P2_X_RST;
      p2_y_q   <= P2_Y_RST;
    end else if (latch_en) begin
      ball_x_q <= ball_x_location;
      ball_y_q <= ball_y_location;
      p1_x_q   <= P1_paddle_x_location;
      p1_y_q   <= P1_paddle_y_location;
      p2_x_q   <= P2_paddle_x_location;
      p2_y_q   <= P2_paddle_y_location;
    end
  end

`ifdef SCORE_DISPLAY_EN
  localparam logic [9:0] P1_DIGIT_X = 10'd280;
  localparam logic [9:0] P2_DIGIT_X = 10'd340;
  localparam logic [9:0] DIGIT_Y    = 10'd16;

  logic [3:0] p1_score_q, p2_score_q;
  logic       p1_digit_hit, p2_digit_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
    end else if (latch_en) begin
      p1_score_q <= P1_score;
      p2_score_q <= P2_score;
    end
  end

  score_digit_glyph u_p1_digit (
    .digit_i(p1_score_q), .org_x_i(P1_DIGIT_X), .org_y_i(DIGIT_Y),
    .x_i(X_pix), .y_i(Y_pix), .hit_o(p1_digit_hit)
  );

  score_digit_glyph u_p2_digit (
    .digit_i(p2_score_q), .org_x_i(P2_DIGIT_X), .org_y_i(DIGIT_Y),
    .x_i(X_pix), .y_i(Y_pix), .hit_o(p2_digit_hit)
  );

  assign digit_hit_d = p1_digit_hit | p2_digit_hit;
`else
  logic unused_scores;
  assign unused_scores = ^{P1_score, P2_score};
  assign digit_hit_d   = 1'b0;
`endif

  assign ball_hit_d = span_hit(X_pix, ball_x_q, 11'(BALL_SIZE)) &&
                      span_hit(Y_pix, ball_y_q, 11'(BALL_SIZE));
  assign p1_hit_d   = span_hit(X_pix, p1_x_q, 11'(PADDLE_W)) &&
                      span_hit(Y_pix, p1_y_q, 11'(PADDLE_H));
  assign p2_hit_d   = span_hit(X_pix, p2_x_q, 11'(PADDLE_W)) &&
                      span_hit(Y_pix, p2_y_q, 11'(PADDLE_H));
  assign net_hit_d  = ((X_pix == 10'(H_ACTIVE / 2 - 1)) || (X_pix == 10'(H_ACTIVE / 2))) &&
                      !Y_pix[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_hit_q   <= 1'b0;
      p1_hit_q     <= 1'b0;
      p2_hit_q     <= 1'b0;
      net_hit_q    <= 1'b0;
      digit_hit_q  <= 1'b0;
      video_on_1_q <= 1'b0;
    end else begin
      ball_hit_q   <= ball_hit_d;
      p1_hit_q     <= p1_hit_d;
      p2_hit_q     <= p2_hit_d;
      net_hit_q    <= net_hit_d;
      digit_hit_q  <= digit_hit_d;
      video_on_1_q <= video_on;
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (video_on_1_q && (state_q != IDLE)) begin
      if (ball_hit_q | p1_hit_q | p2_hit_q | net_hit_q | digit_hit_q) rgb_d = FG_RGB;
      else                                                            rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q        <= 12'h000;
      video_on_2_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      video_on_2_q <= video_on_1_q;
    end
  end

  assign rgb        = rgb_q;
  assign video_on_d = video_on_2_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer; score-digit checks run when SCORE_DISPLAY_EN is defined.
module tb_pong_frame_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  X_pix, Y_pix;
  logic        video_on;
  logic [9:0]  ball_x_location, ball_y_location;
  logic [9:0]  P1_paddle_x_location, P1_paddle_y_location;
  logic [9:0]  P2_paddle_x_location, P2_paddle_y_location;
  logic [3:0]  P1_score, P2_score;
  logic [11:0] rgb;
  logic        video_on_d;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pong_frame_renderer dut (
    .clk(clk), .reset(reset), .X_pix(X_pix), .Y_pix(Y_pix), .video_on(video_on),
    .ball_x_location(ball_x_location), .ball_y_location(ball_y_location),
    .P1_paddle_x_location(P1_paddle_x_location), .P1_paddle_y_location(P1_paddle_y_location),
    .P2_paddle_x_location(P2_paddle_x_location), .P2_paddle_y_location(P2_paddle_y_location),
    .P1_score(P1_score), .P2_score(P2_score),
    .rgb(rgb), .video_on_d(video_on_d), .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present one pixel, then read rgb two clock edges later.
  task automatic probe(input string tag, input int x, input int y, input logic von,
                       input logic [11:0] exp);
    @(negedge clk);
    X_pix    = 10'(x);
    Y_pix    = 10'(y);
    video_on = von;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, rgb, exp);
  endtask

  // Walk into vertical blank and count frame_tick pulses.
  task automatic go_blank(input string tag);
    int ticks;
    ticks = 0;
    @(negedge clk);
    X_pix = 10'd799; Y_pix = 10'd479; video_on = 1'b0;
    @(negedge clk);
    X_pix = 10'd0;   Y_pix = 10'd480;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      X_pix = 10'(i + 1);
    end
    check(tag, 12'(ticks), 12'd1);
  endtask

  int          s_x[8]   = '{318, 323, 320, 322, 100, 319, 319, 0};
  int          s_y[8]   = '{238, 238, 238, 242, 100, 0,   0,   0};
  logic        s_von[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [11:0] s_rgb[8] = '{FG, BG, BG, FG, BG, BG, FG, BG};

  initial begin
    reset = 1'b1;
    X_pix = 10'd0; Y_pix = 10'd0; video_on = 1'b0;
    ball_x_location = 10'd318; ball_y_location = 10'd238;
    P1_paddle_x_location = 10'd20;  P1_paddle_y_location = 10'd180;
    P2_paddle_x_location = 10'd610; P2_paddle_y_location = 10'd180;
    P1_score = 4'd0; P2_score = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", rgb, 12'h000);
    check("rst_von_d", {11'b0, video_on_d}, 12'h000);
    check("rst_tick", {11'b0, frame_tick}, 12'h000);
    reset = 1'b0;

    probe("idle_black", 318, 238, 1'b1, 12'h000);
    go_blank("tick_frame1");

    probe("ball_tl", 318, 238, 1'b1, FG);
    probe("ball_br", 322, 242, 1'b1, FG);
    probe("ball_right_edge", 323, 238, 1'b1, BG);
    probe("ball_left_edge", 317, 240, 1'b1, BG);
    probe("ball_video_off", 318, 238, 1'b0, 12'h000);
    probe("net_dash_on", 320, 0, 1'b1, FG);
    probe("net_dash_off", 320, 8, 1'b1, BG);
    probe("net_right", 321, 0, 1'b1, BG);

    // Back-to-back pixels: rgb and video_on_d two cycles behind the inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("stream_rgb", rgb, s_rgb[i-2]);
        check("stream_von_d", {11'b0, video_on_d}, {11'b0, s_von[i-2]});
      end
      if (i < 8) begin
        X_pix = 10'(s_x[i]); Y_pix = 10'(s_y[i]); video_on = s_von[i];
      end else begin
        X_pix = 10'd5; Y_pix = 10'd5; video_on = 1'b0;
      end
    end

    // Mid-frame position change waits for the next blank.
    probe("line200", 10, 200, 1'b1, BG);
    ball_x_location = 10'd100;
    probe("midframe_old_ball", 318, 238, 1'b1, FG);
    probe("midframe_no_new", 100, 238, 1'b1, BG);
    go_blank("tick_frame2");
    probe("new_ball_tl", 100, 238, 1'b1, FG);
    probe("new_ball_br", 104, 242, 1'b1, FG);
    probe("new_ball_edge", 105, 238, 1'b1, BG);
    probe("old_ball_gone", 318, 238, 1'b1, BG);

    // Paddle edges.
    P1_paddle_y_location = 10'd160;
    go_blank("tick_frame3");
    probe("p1_x_last", 29, 160, 1'b1, FG);
    probe("p1_x_past", 30, 160, 1'b1, BG);
    probe("p1_y_last", 25, 279, 1'b1, FG);
    probe("p1_y_past", 25, 280, 1'b1, BG);
    probe("p1_y_before", 20, 159, 1'b1, BG);
    probe("p2_inside", 615, 200, 1'b1, FG);

    // Ball near the right limit must not wrap onto column 0.
    ball_x_location = 10'd1020;
    ball_y_location = 10'd0;
    go_blank("tick_frame4");
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 4; x++)
        probe("no_wrap", x, y, 1'b1, BG);

    // Reset mid-frame blacks the output until the next latch.
    probe("pre_rst_fg", 25, 240, 1'b1, FG);
    @(negedge clk);
    X_pix = 10'd300; Y_pix = 10'd240; video_on = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_midframe_rgb", rgb, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    probe("rst_idle_black", 25, 240, 1'b1, 12'h000);
    go_blank("tick_after_rst");
    probe("post_rst_paddle", 25, 240, 1'b1, FG);
    probe("post_rst_latched", 318, 238, 1'b1, BG);

`ifdef SCORE_DISPLAY_EN
    P1_score = 4'd8;
    go_blank("tick_score8");
    probe("seg_a", 290, 17, 1'b1, FG);
    probe("seg_b", 298, 26, 1'b1, FG);
    probe("seg_c", 298, 46, 1'b1, FG);
    probe("seg_d", 290, 54, 1'b1, FG);
    probe("seg_e", 281, 46, 1'b1, FG);
    probe("seg_f", 281, 26, 1'b1, FG);
    probe("seg_g", 290, 35, 1'b1, FG);
    probe("digit_hole", 290, 26, 1'b1, BG);
    P1_score = 4'd12;
    go_blank("tick_score12");
    probe("blank_a", 290, 17, 1'b1, BG);
    probe("blank_b", 298, 26, 1'b1, BG);
    probe("blank_g", 290, 35, 1'b1, BG);
    probe("blank_d", 290, 54, 1'b1, BG);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
